// File: rtl/program_loader_pkg.sv
// Shared CPU package: control-unit state constants and the program loader FSM encoding.
package program_loader_pkg;

    typedef enum logic [1:0] {
        CU_FETCH,
        CU_DECODE,
        CU_EXECUTE,
        CU_PROGRAM
    } cu_state_t;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_REQ,
        LD_LOAD,
        LD_FILL,
        LD_RELEASE
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Streams host words into program memory while the control unit holds its program state,
// optionally zero-filling the unwritten tail, then hands the control unit back.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_ADDRESS_WIDTH = 4,
    parameter bit FILL_ZERO            = 1'b1
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic                            start_i,
    input  logic                            host_valid_i,
    input  logic [REGISTER_WIDTH-1:0]       host_data_i,
    input  logic                            host_last_i,
    output logic                            host_ready_o,
    output logic                            p_program_o,
    input  logic                            p_active_i,
    output logic                            p_write_en_mem_o,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] p_address_o,
    output logic [REGISTER_WIDTH-1:0]       p_data_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            overflow_o,
    output logic [MEMORY_ADDRESS_WIDTH:0]   word_count_o
);

    localparam logic [MEMORY_ADDRESS_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [MEMORY_ADDRESS_WIDTH-1:0] ADDR_ONE  = 1;
    localparam logic [MEMORY_ADDRESS_WIDTH:0]   COUNT_ONE = 1;

    loader_state_t                   r_state;
    loader_state_t                   w_next_state;
    logic [MEMORY_ADDRESS_WIDTH-1:0] r_addr;
    logic [MEMORY_ADDRESS_WIDTH:0]   r_count;
    logic                            r_overflow;
    logic                            r_fill_pending;
    logic                            r_we;
    logic [MEMORY_ADDRESS_WIDTH-1:0] r_paddr;
    logic [REGISTER_WIDTH-1:0]       r_pdata;
    logic                            r_done;

    logic w_start;
    logic w_accept;
    logic w_fill_wr;
    logic w_set_overflow;
    logic w_set_fill;
    logic w_at_last;

    assign w_at_last    = (r_addr == LAST_ADDR);
    assign host_ready_o = (r_state == LD_LOAD) && p_active_i;
    assign p_program_o  = (r_state == LD_REQ) || (r_state == LD_LOAD) || (r_state == LD_FILL);
    assign busy_o       = (r_state != LD_IDLE);

    always_comb begin
        // NOTE: every signal gets its default before the case, so no path can infer a latch.
        w_next_state   = r_state;
        w_start        = 1'b0;
        w_accept       = 1'b0;
        w_fill_wr      = 1'b0;
        w_set_overflow = 1'b0;
        w_set_fill     = 1'b0;
        case (r_state)
            LD_IDLE: begin
                if (start_i) begin
                    w_start      = 1'b1;
                    w_next_state = LD_REQ;
                end
            end
            LD_REQ: begin
                // A load interrupted during the zero fill resumes filling, not accepting.
                if (p_active_i) w_next_state = r_fill_pending ? LD_FILL : LD_LOAD;
            end
            LD_LOAD: begin
                if (!p_active_i) begin
                    w_next_state = LD_REQ;
                end else if (host_valid_i) begin
                    w_accept = 1'b1;
                    if (w_at_last) begin
                        w_next_state   = LD_RELEASE;
                        w_set_overflow = !host_last_i;
                    end else if (host_last_i) begin
                        w_next_state = FILL_ZERO ? LD_FILL : LD_RELEASE;
                        w_set_fill   = FILL_ZERO;
                    end
                end
            end
            LD_FILL: begin
                if (!p_active_i) begin
                    w_next_state = LD_REQ;
                end else begin
                    w_fill_wr = 1'b1;
                    if (w_at_last) w_next_state = LD_RELEASE;
                end
            end
            LD_RELEASE: begin
                if (!r_we && !p_active_i) w_next_state = LD_IDLE;
            end
            default: w_next_state = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state        <= LD_IDLE;
            r_addr         <= '0;
            r_count        <= '0;
            r_overflow     <= 1'b0;
            r_fill_pending <= 1'b0;
            r_we           <= 1'b0;
            r_paddr        <= '0;
            r_pdata        <= '0;
            r_done         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next_state;
            r_we    <= w_accept || w_fill_wr;
            r_done  <= (r_state == LD_RELEASE) && (w_next_state == LD_IDLE);
            if (w_start) begin
                r_addr         <= '0;
                r_count        <= '0;
                r_overflow     <= 1'b0;
                r_fill_pending <= 1'b0;
            end
            if (w_accept || w_fill_wr) begin
                r_paddr <= r_addr;
                r_pdata <= w_accept ? host_data_i : '0;
                if (!w_at_last) r_addr <= r_addr + ADDR_ONE;
            end
            if (w_accept) r_count <= r_count + COUNT_ONE;
            if (w_set_overflow) r_overflow <= 1'b1;
            if (w_set_fill) r_fill_pending <= 1'b1;
        end
    end

    assign p_write_en_mem_o = r_we;
    assign p_address_o      = r_paddr;
    assign p_data_o         = r_pdata;
    assign done_o           = r_done;
    assign overflow_o       = r_overflow;
    assign word_count_o     = r_count;

endmodule
